fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Upstream stage of the decoder. Reads opcode and operand bytes from memory at PC and resolves
//  the effective address for the 6502 addressing mode. Presents instruction/addr/operand with
//  instruction_ready, then holds them until the decoder returns instruction_done.
//  It then writes the next PC and starts the following fetch.
// PARAMETERS
//  REG_WIDTH   8   data/opcode width
//  ADDR_WIDTH  16  address width
// PORTS
//  clk               in   1   clock, all state updates on posedge
//  reset_n           in   1   synchronous, active-low reset
//  pc_in             in   16  current PC from PC register
//  x_in / y_in       in   8   index registers X, Y
//  mem_addr          out  16  memory read address
//  mem_rd            out  1   read strobe; mem_rdata valid on the cycle after mem_rd=1
//  mem_rdata         in   8   memory read data
//  instruction       out  8   latched opcode (decoder instruction_in)
//  addr              out  16  effective address; for immediate mode, address of the operand byte (decoder addr_in)
//  operand           out  8   first operand byte (immediate value / relative offset)
//  instruction_ready out  1   level, high while outputs are valid for the decoder
//  instruction_done  in   1   level from decoder; current instruction is finished
//  pc_out            out  16  next PC = PC + length
//  pc_we             out  1   one-cycle write pulse for pc_out
// BEHAVIOUR
//  Reset (reset_n=0 at posedge), including mid-fetch: state=S_OP; mem_rd, pc_we, instruction_ready=0;
//   instruction=0, addr=0, operand=0, pc_out=0, mem_addr=0. PC is re-sampled from pc_in in S_OP.
//  Mode/length decoding uses cc=op[1:0] and bbb=op[4:2].
//   cc=01: 000 (zp,X); 001 zpg; 010 imm; 011 abs; 100 (zp),Y; 101 zpg,X; 110 abs,Y; 111 abs,X.
//   cc=00/10: 000 imm; 001 zpg; 010 implied/acc (len 1); 011 abs; 100 rel (len 2);
//    101 zpg,X; 110 implied (len 1); 111 abs,X.
//    For cc=10 with aaa=op[7:5] in {100,101}, the X index is replaced by Y.
//   cc=11: implied, len 1. The opcode is passed through and the decoder flags it as illegal.
//   Lengths: 1 for implied/acc; 2 for imm, rel, zpg, zpg-indexed and indirect modes; 3 for abs modes.
//  FSM. Each read is issued in one state and its data is captured in the next state.
//   S_OP : mem_addr=pc_in, mem_rd=1; latch PC.
//   S_B1 : capture opcode. len1 -> S_RDY; else issue PC+1 -> S_B2.
//   S_B2 : capture byte1 into operand.
//          abs modes: issue PC+2 -> S_B3.
//          (zp,X): issue ptr=(b1+X)&FF -> S_P1.
//          (zp),Y: issue ptr=b1 -> S_P1.
//          Other modes -> S_RDY.
//   S_B3 : capture hi byte -> S_RDY.
//   S_P1 : capture ptr lo; issue (ptr+1)&FF (zero-page wrap) -> S_P2.
//   S_P2 : capture ptr hi -> S_RDY.
//   S_RDY: instruction_ready=1. Wait for instruction_done=1, then drive pc_out=PC+len, pc_we=1
//          for one cycle, ready=0 -> S_OP.
//  Effective address:
//   zpg = {00,b1}; zpg,X/Y = {00,(b1+idx)&FF}, no carry into the high byte.
//   abs = {hi,lo}; abs,X/Y = ({hi,lo}+idx) mod 2^16.
//   (zp,X) = {mem[(ptr+1)&FF], mem[ptr]}; (zp),Y = ({mem[(b1+1)&FF], mem[b1]}+Y) mod 2^16.
//   imm/rel/implied: addr = PC+1 mod 2^16.
//  X and Y are sampled in the state that forms the address and are not re-read afterwards.
//  Cycles from S_OP entry to ready=1: len1=2; imm/zpg/rel=3; abs=4; indirect=5.
//  instruction_ready drops for at least 2 cycles between instructions, which guarantees a rising
//   edge per instruction. An instruction_done already high on entry to S_RDY is accepted in that cycle.
//  PC+len wraps modulo 2^16 (FFFF+1=0000). mem_rd=0 in S_RDY.
// STRUCTURE
//  Shared defines header: addressing-mode codes (AM_IMP, AM_IMM, AM_ZPG, AM_ZPX, AM_ZPY, AM_ABS,
//   AM_ABX, AM_ABY, AM_INX, AM_INY, AM_REL) and FSM state encodings.
//  Sub-module fetch_mode_lut: combinational opcode -> {mode[3:0], len[1:0]}.
//   The FSM and address arithmetic stay in fetch_unit.
// TESTING
//  1. pc_in=0200, mem[0200]=A9, mem[0201]=42 (LDA #) -> ready at cycle 3, operand=42, addr=0201;
//     done -> pc_out=0202, pc_we for 1 cycle.
//  2. X=10, mem[0300]=B5, mem[0301]=F8 (LDA zp,X) -> addr=0008 (page-zero wrap), pc_out=0302.
//  3. Y=01, mem[0400]=B9,FF,12 (LDA abs,Y) -> addr=1300 at cycle 4, pc_out=0403.
//  4. X=04, mem[0500]=A1,FB (LDA (zp,X)), mem[00FF]=34, mem[0000]=12 -> addr=1234 at cycle 5.
//  5. Y=02, mem[0600]=B1,FF (LDA (zp),Y), mem[00FF]=FF, mem[0000]=20 -> addr=2101;
//     also pc_in=FFFF with opcode EA (NOP) -> pc_out=0000.
//  6. reset_n=0 during S_P1 -> next cycle ready=0, mem_rd=0, pc_we=0, state S_OP;
//     after release, fetch restarts at pc_in.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the 6502 fetch stage: widths, addressing-mode codes,
// FSM state encodings and the mode-to-length helper.
package fetch_unit_pkg;

    localparam int unsigned REG_WIDTH  = 8;
    localparam int unsigned ADDR_WIDTH = 16;

    typedef enum logic [3:0] {
        AM_IMP = 4'd0,
        AM_IMM = 4'd1,
        AM_ZPG = 4'd2,
        AM_ZPX = 4'd3,
        AM_ZPY = 4'd4,
        AM_ABS = 4'd5,
        AM_ABX = 4'd6,
        AM_ABY = 4'd7,
        AM_INX = 4'd8,
        AM_INY = 4'd9,
        AM_REL = 4'd10
    } addr_mode_e;

    typedef enum logic [2:0] {
        S_OP  = 3'd0,
        S_B1  = 3'd1,
        S_B2  = 3'd2,
        S_B3  = 3'd3,
        S_P1  = 3'd4,
        S_P2  = 3'd5,
        S_RDY = 3'd6
    } fetch_state_e;

    function automatic logic [1:0] mode_len(addr_mode_e mode);
        case (mode)
            AM_IMP:                 return 2'd1;
            AM_ABS, AM_ABX, AM_ABY: return 2'd3;
            default:                return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Memory read port and decoder handshake of the fetch stage.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd;
    logic [REG_WIDTH-1:0]  mem_rdata;
    logic [REG_WIDTH-1:0]  instruction;
    logic [ADDR_WIDTH-1:0] addr;
    logic [REG_WIDTH-1:0]  operand;
    logic                  instruction_ready;
    logic                  instruction_done;
    logic [ADDR_WIDTH-1:0] pc_out;
    logic                  pc_we;

    modport master (
        output mem_addr, mem_rd, instruction, addr, operand, instruction_ready, pc_out, pc_we,
        input  mem_rdata, instruction_done
    );

    modport slave (
        input  mem_addr, mem_rd, instruction, addr, operand, instruction_ready, pc_out, pc_we,
        output mem_rdata, instruction_done
    );

endinterface

// File: rtl/fetch_mode_lut.sv
// Combinational opcode decode into 6502 addressing mode and instruction length.
module fetch_mode_lut import fetch_unit_pkg::*; (
    input  logic [REG_WIDTH-1:0] i_opcode,
    output addr_mode_e           o_mode,
    output logic [1:0]           o_len
);

    logic [1:0] w_cc;
    logic [2:0] w_bbb;
    logic       w_use_y;

    assign w_cc    = i_opcode[1:0];
    assign w_bbb   = i_opcode[4:2];
    // LDX/STX families (aaa = 100/101) index with Y instead of X
    assign w_use_y = (w_cc == 2'b10) && (i_opcode[7:6] == 2'b10);

    always_comb begin
        o_mode = AM_IMP;
        if (w_cc == 2'b01) begin
            case (w_bbb)
                3'b000: o_mode = AM_INX;
                3'b001: o_mode = AM_ZPG;
                3'b010: o_mode = AM_IMM;
                3'b011: o_mode = AM_ABS;
                3'b100: o_mode = AM_INY;
                3'b101: o_mode = AM_ZPX;
                3'b110: o_mode = AM_ABY;
                3'b111: o_mode = AM_ABX;
                default: o_mode = AM_IMP;
            endcase
        end else if (w_cc != 2'b11) begin
            case (w_bbb)
                3'b000: o_mode = AM_IMM;
                3'b001: o_mode = AM_ZPG;
                3'b010: o_mode = AM_IMP;
                3'b011: o_mode = AM_ABS;
                3'b100: o_mode = AM_REL;
                3'b101: o_mode = w_use_y ? AM_ZPY : AM_ZPX;
                3'b110: o_mode = AM_IMP;
                3'b111: o_mode = w_use_y ? AM_ABY : AM_ABX;
                default: o_mode = AM_IMP;
            endcase
        end
    end

    assign o_len = mode_len(o_mode);

endmodule

// File: rtl/fetch_unit.sv
// 6502 fetch stage: reads opcode/operands at PC, resolves the effective address,
// hands the instruction to the decoder and writes back the next PC.
module fetch_unit import fetch_unit_pkg::*; (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic [REG_WIDTH-1:0]  i_x,
    input  logic [REG_WIDTH-1:0]  i_y,
    fetch_unit_if.master          fetch_bus
);

    fetch_state_e          r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc, w_pc_next;
    logic [REG_WIDTH-1:0]  r_instr, w_instr_next;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
    logic [REG_WIDTH-1:0]  r_operand, w_operand_next;
    logic [REG_WIDTH-1:0]  r_ptr, w_ptr_next;
    logic [REG_WIDTH-1:0]  r_ptr_lo, w_ptr_lo_next;

    logic [ADDR_WIDTH-1:0] w_mem_addr, w_pc_out;
    logic                  w_mem_rd, w_ready, w_pc_we;
    logic [REG_WIDTH-1:0]  w_op, w_rdata, w_zp_x, w_zp_y, w_ptr_inc;
    logic [ADDR_WIDTH-1:0] w_pc_inc1, w_pc_inc2;
    addr_mode_e            w_mode;
    logic [1:0]            w_len;

    // The opcode is decoded straight off the bus in the cycle it is captured
    assign w_op      = (r_state == S_B1) ? fetch_bus.mem_rdata : r_instr;
    assign w_rdata   = fetch_bus.mem_rdata;
    assign w_zp_x    = w_rdata + i_x;
    assign w_zp_y    = w_rdata + i_y;
    assign w_ptr_inc = r_ptr + 8'd1;
    assign w_pc_inc1 = r_pc + 16'd1;
    assign w_pc_inc2 = r_pc + 16'd2;

    fetch_mode_lut u_mode_lut (
        .i_opcode (w_op),
        .o_mode   (w_mode),
        .o_len    (w_len)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_OP;
            r_pc      <= '0;
            r_instr   <= '0;
            r_addr    <= '0;
            r_operand <= '0;
            r_ptr     <= '0;
            r_ptr_lo  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_instr   <= w_instr_next;
            r_addr    <= w_addr_next;
            r_operand <= w_operand_next;
            r_ptr     <= w_ptr_next;
            r_ptr_lo  <= w_ptr_lo_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_instr_next   = r_instr;
        w_addr_next    = r_addr;
        w_operand_next = r_operand;
        w_ptr_next     = r_ptr;
        w_ptr_lo_next  = r_ptr_lo;
        w_mem_addr     = '0;
        w_mem_rd       = 1'b0;
        w_ready        = 1'b0;
        w_pc_we        = 1'b0;
        w_pc_out       = '0;
        case (r_state)
            S_OP: begin
                w_mem_addr   = i_pc;
                w_mem_rd     = 1'b1;
                w_pc_next    = i_pc;
                w_state_next = S_B1;
            end
            S_B1: begin
                w_instr_next = w_rdata;
                if (w_len == 2'd1) begin
                    w_addr_next    = w_pc_inc1;
                    w_operand_next = '0;
                    w_state_next   = S_RDY;
                end else begin
                    w_mem_addr   = w_pc_inc1;
                    w_mem_rd     = 1'b1;
                    w_state_next = S_B2;
                end
            end
            S_B2: begin
                w_operand_next = w_rdata;
                w_state_next   = S_RDY;
                case (w_mode)
                    AM_ABS, AM_ABX, AM_ABY: begin
                        w_mem_addr   = w_pc_inc2;
                        w_mem_rd     = 1'b1;
                        w_state_next = S_B3;
                    end
                    AM_INX, AM_INY: begin
                        w_ptr_next   = (w_mode == AM_INX) ? w_zp_x : w_rdata;
                        w_mem_addr   = {8'h00, w_ptr_next};
                        w_mem_rd     = 1'b1;
                        w_state_next = S_P1;
                    end
                    AM_ZPG:  w_addr_next = {8'h00, w_rdata};
                    AM_ZPX:  w_addr_next = {8'h00, w_zp_x};
                    AM_ZPY:  w_addr_next = {8'h00, w_zp_y};
                    default: w_addr_next = w_pc_inc1;
                endcase
            end
            S_B3: begin
                w_addr_next = {w_rdata, r_operand}
                            + ((w_mode == AM_ABX) ? {8'h00, i_x} :
                               (w_mode == AM_ABY) ? {8'h00, i_y} : 16'h0000);
                w_state_next = S_RDY;
            end
            S_P1: begin
                w_ptr_lo_next = w_rdata;
                w_mem_addr    = {8'h00, w_ptr_inc};
                w_mem_rd      = 1'b1;
                w_state_next  = S_P2;
            end
            S_P2: begin
                w_addr_next  = {w_rdata, r_ptr_lo}
                             + ((w_mode == AM_INY) ? {8'h00, i_y} : 16'h0000);
                w_state_next = S_RDY;
            end
            S_RDY: begin
                w_ready  = 1'b1;
                w_pc_out = r_pc + {14'd0, w_len};
                if (fetch_bus.instruction_done) begin
                    w_pc_we      = 1'b1;
                    w_state_next = S_OP;
                end
            end
            default: w_state_next = S_OP;
        endcase
    end

    // Bus strobes stay quiet while reset is held, even though the state is already S_OP
    assign fetch_bus.mem_addr          = reset_n ? w_mem_addr : '0;
    assign fetch_bus.mem_rd            = w_mem_rd & reset_n;
    assign fetch_bus.pc_we             = w_pc_we & reset_n;
    assign fetch_bus.pc_out            = w_pc_out;
    assign fetch_bus.instruction_ready = w_ready;
    assign fetch_bus.instruction       = r_instr;
    assign fetch_bus.addr              = r_addr;
    assign fetch_bus.operand           = r_operand;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency memory model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] pc = 16'h0000;
    logic [7:0]  x = 8'h00;
    logic [7:0]  y = 8'h00;
    logic [7:0]  mem [0:65535];
    logic [7:0]  rdata = 8'h00;
    int          n_tests = 0;
    int          n_fail = 0;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_pc      (pc),
        .i_x       (x),
        .i_y       (y),
        .fetch_bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.mem_rd) rdata <= mem[bus.mem_addr];
    assign bus.mem_rdata = rdata;

    // Called just after the posedge that enters S_OP; counts cycles until ready
    task automatic wait_ready(output int cyc);
        cyc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.instruction_ready) begin
                cyc = i;
                return;
            end
            @(posedge clk);
        end
    endtask

    // Called at the negedge of an S_RDY cycle; returns just after the next posedge
    task automatic do_done(output logic we, output logic [15:0] pco,
                           output logic we_after, output logic rdy_after);
        bus.instruction_done = 1'b1;
        #1;
        we  = bus.pc_we;
        pco = bus.pc_out;
        @(posedge clk);
        #1;
        bus.instruction_done = 1'b0;
        we_after  = bus.pc_we;
        rdy_after = bus.instruction_ready;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        pc = 16'h1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (bus.instruction_ready !== 1'b0) begin n_fail++;
            $display("FAIL rst_ready: got %b want 0", bus.instruction_ready); end
        n_tests++; if (bus.mem_rd !== 1'b0) begin n_fail++;
            $display("FAIL rst_mem_rd: got %b want 0", bus.mem_rd); end
        n_tests++; if (bus.mem_addr !== 16'h0000) begin n_fail++;
            $display("FAIL rst_mem_addr: got %h want 0000", bus.mem_addr); end
        n_tests++; if (bus.pc_we !== 1'b0) begin n_fail++;
            $display("FAIL rst_pc_we: got %b want 0", bus.pc_we); end
        n_tests++; if ({bus.instruction, bus.operand, bus.addr, bus.pc_out} !== 40'h0) begin
            n_fail++; $display("FAIL rst_regs: got %h %h %h %h want all 0",
                               bus.instruction, bus.operand, bus.addr, bus.pc_out); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_imm();
        int cyc; logic we, we_a, rdy_a; logic [15:0] pco;
        pc = 16'h0200; mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h42;
        wait_ready(cyc);
        n_tests++; if (cyc !== 3) begin n_fail++;
            $display("FAIL imm_cycles: got %0d want 3", cyc); end
        n_tests++; if (bus.instruction !== 8'hA9) begin n_fail++;
            $display("FAIL imm_instr: got %h want a9", bus.instruction); end
        n_tests++; if (bus.operand !== 8'h42) begin n_fail++;
            $display("FAIL imm_operand: got %h want 42", bus.operand); end
        n_tests++; if (bus.addr !== 16'h0201) begin n_fail++;
            $display("FAIL imm_addr: got %h want 0201", bus.addr); end
        n_tests++; if (bus.mem_rd !== 1'b0) begin n_fail++;
            $display("FAIL imm_rdy_mem_rd: got %b want 0", bus.mem_rd); end
        do_done(we, pco, we_a, rdy_a);
        n_tests++; if (we !== 1'b1 || pco !== 16'h0202) begin n_fail++;
            $display("FAIL imm_pc_write: got we=%b pc=%h want 1 0202", we, pco); end
        n_tests++; if (we_a !== 1'b0 || rdy_a !== 1'b0) begin n_fail++;
            $display("FAIL imm_after_done: got we=%b rdy=%b want 0 0", we_a, rdy_a); end
    endtask

    task automatic test_zp_indexed();
        int cyc; logic we, we_a, rdy_a; logic [15:0] pco;
        x = 8'h10; pc = 16'h0300; mem[16'h0300] = 8'hB5; mem[16'h0301] = 8'hF8;
        wait_ready(cyc);
        n_tests++; if (cyc !== 3 || bus.addr !== 16'h0008) begin n_fail++;
            $display("FAIL zpx_addr: got cyc=%0d addr=%h want 3 0008", cyc, bus.addr); end
        do_done(we, pco, we_a, rdy_a);
        n_tests++; if (pco !== 16'h0302) begin n_fail++;
            $display("FAIL zpx_pc_out: got %h want 0302", pco); end
        // LDX zp,Y: cc=10 with aaa=101 indexes by Y
        y = 8'h05; pc = 16'h0310; mem[16'h0310] = 8'hB6; mem[16'h0311] = 8'h80;
        wait_ready(cyc);
        n_tests++; if (cyc !== 3 || bus.addr !== 16'h0085) begin n_fail++;
            $display("FAIL zpy_addr: got cyc=%0d addr=%h want 3 0085", cyc, bus.addr); end
        do_done(we, pco, we_a, rdy_a);
        // BEQ rel: addr is PC+1, operand the offset
        pc = 16'h0320; mem[16'h0320] = 8'hF0; mem[16'h0321] = 8'h05;
        wait_ready(cyc);
        n_tests++; if (cyc !== 3 || bus.addr !== 16'h0321 || bus.operand !== 8'h05) begin
            n_fail++; $display("FAIL rel_fetch: got cyc=%0d addr=%h op=%h want 3 0321 05",
                               cyc, bus.addr, bus.operand); end
        do_done(we, pco, we_a, rdy_a);
        n_tests++; if (pco !== 16'h0322) begin n_fail++;
            $display("FAIL rel_pc_out: got %h want 0322", pco); end
    endtask

    task automatic test_abs_y();
        int cyc; logic we, we_a, rdy_a; logic [15:0] pco;
        y = 8'h01; pc = 16'h0400;
        mem[16'h0400] = 8'hB9; mem[16'h0401] = 8'hFF; mem[16'h0402] = 8'h12;
        wait_ready(cyc);
        n_tests++; if (cyc !== 4 || bus.addr !== 16'h1300) begin n_fail++;
            $display("FAIL aby_addr: got cyc=%0d addr=%h want 4 1300", cyc, bus.addr); end
        do_done(we, pco, we_a, rdy_a);
        n_tests++; if (pco !== 16'h0403) begin n_fail++;
            $display("FAIL aby_pc_out: got %h want 0403", pco); end
    endtask

    task automatic test_ind_x();
        int cyc; logic we, we_a, rdy_a; logic [15:0] pco;
        x = 8'h04; pc = 16'h0500; mem[16'h0500] = 8'hA1; mem[16'h0501] = 8'hFB;
        mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12;
        wait_ready(cyc);
        n_tests++; if (cyc !== 5 || bus.addr !== 16'h1234) begin n_fail++;
            $display("FAIL inx_addr: got cyc=%0d addr=%h want 5 1234", cyc, bus.addr); end
        do_done(we, pco, we_a, rdy_a);
        n_tests++; if (pco !== 16'h0502) begin n_fail++;
            $display("FAIL inx_pc_out: got %h want 0502", pco); end
    endtask

    task automatic test_ind_y_and_wrap();
        int cyc; logic we, we_a, rdy_a; logic [15:0] pco;
        y = 8'h02; pc = 16'h0600; mem[16'h0600] = 8'hB1; mem[16'h0601] = 8'hFF;
        mem[16'h00FF] = 8'hFF; mem[16'h0000] = 8'h20;
        wait_ready(cyc);
        n_tests++; if (cyc !== 5 || bus.addr !== 16'h2101) begin n_fail++;
            $display("FAIL iny_addr: got cyc=%0d addr=%h want 5 2101", cyc, bus.addr); end
        do_done(we, pco, we_a, rdy_a);
        n_tests++; if (pco !== 16'h0602) begin n_fail++;
            $display("FAIL iny_pc_out: got %h want 0602", pco); end
        pc = 16'hFFFF; mem[16'hFFFF] = 8'hEA;
        wait_ready(cyc);
        n_tests++; if (cyc !== 2 || bus.instruction !== 8'hEA || bus.addr !== 16'h0000) begin
            n_fail++; $display("FAIL nop_fetch: got cyc=%0d ins=%h addr=%h want 2 ea 0000",
                               cyc, bus.instruction, bus.addr); end
        do_done(we, pco, we_a, rdy_a);
        n_tests++; if (we !== 1'b1 || pco !== 16'h0000) begin n_fail++;
            $display("FAIL nop_pc_wrap: got we=%b pc=%h want 1 0000", we, pco); end
    endtask

    task automatic test_done_early();
        int cyc;
        pc = 16'h0330; mem[16'h0330] = 8'hEA;
        bus.instruction_done = 1'b1;
        wait_ready(cyc);
        #1;
        n_tests++; if (cyc !== 2 || bus.pc_we !== 1'b1 || bus.pc_out !== 16'h0331) begin
            n_fail++; $display("FAIL early_done: got cyc=%0d we=%b pc=%h want 2 1 0331",
                               cyc, bus.pc_we, bus.pc_out); end
        @(posedge clk);
        #1;
        bus.instruction_done = 1'b0;
        n_tests++; if (bus.instruction_ready !== 1'b0 || bus.pc_we !== 1'b0) begin n_fail++;
            $display("FAIL early_done_drop: got rdy=%b we=%b want 0 0",
                     bus.instruction_ready, bus.pc_we); end
    endtask

    task automatic test_reset_mid();
        int cyc; logic we, we_a, rdy_a; logic [15:0] pco;
        x = 8'h04; pc = 16'h0500;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0000) begin n_fail++;
            $display("FAIL p1_read: got rd=%b addr=%h want 1 0000", bus.mem_rd, bus.mem_addr);
        end
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_tests++; if (bus.instruction_ready !== 1'b0 || bus.mem_rd !== 1'b0 ||
                       bus.pc_we !== 1'b0) begin n_fail++;
            $display("FAIL mid_rst_ctl: got rdy=%b rd=%b we=%b want 0 0 0",
                     bus.instruction_ready, bus.mem_rd, bus.pc_we); end
        n_tests++; if (bus.instruction !== 8'h00 || bus.addr !== 16'h0000) begin n_fail++;
            $display("FAIL mid_rst_regs: got ins=%h addr=%h want 00 0000",
                     bus.instruction, bus.addr); end
        @(posedge clk);
        #1;
        reset_n = 1'b1; pc = 16'h0700; mem[16'h0700] = 8'hEA;
        #1;
        n_tests++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0700) begin n_fail++;
            $display("FAIL restart_read: got rd=%b addr=%h want 1 0700",
                     bus.mem_rd, bus.mem_addr); end
        wait_ready(cyc);
        n_tests++; if (cyc !== 2 || bus.addr !== 16'h0701) begin n_fail++;
            $display("FAIL restart_fetch: got cyc=%0d addr=%h want 2 0701", cyc, bus.addr); end
        do_done(we, pco, we_a, rdy_a);
        n_tests++; if (pco !== 16'h0701) begin n_fail++;
            $display("FAIL restart_pc_out: got %h want 0701", pco); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        bus.instruction_done = 1'b0;
        test_reset();
        test_imm();
        test_zp_indexed();
        test_abs_y();
        test_ind_x();
        test_ind_y_and_wrap();
        test_done_early();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
